// File: rtl/hicore_tcm_ctrl_2p_pkg.sv
// Shared constants and types for the two-port TCM controller.
// Optional build macro: HICORE_TCM_RR_ARB_EN (round-robin arbitration).
package hicore_tcm_ctrl_2p_pkg;

    localparam int HiCore_ADDR_SIZE = 32;
    localparam int HiCore_REG_SIZE  = 32;

    localparam logic [31:0] TCM_BASE_ADDR = 32'h9000_0000;
    localparam int          TCM_RAM_AW    = 14;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // What a response buffer needs to know about the command accepted this cycle.
    typedef struct packed {
        logic acc;
        logic read;
        logic err;
    } rsp_req_t;

    // Width of the byte offset inside one RAM word.
    function automatic int byte_ofs_w(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/hicore_tcm_ctrl_2p_if.sv
// ICB command/response port bundle; one instance per controller port.
interface hicore_tcm_ctrl_2p_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            icb_cmd_valid;
    logic            icb_cmd_ready;
    logic            icb_cmd_read;
    logic [AW-1:0]   icb_cmd_addr;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_rsp_valid;
    logic            icb_rsp_ready;
    logic            icb_rsp_err;
    logic [DW-1:0]   icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/hicore_tcm_rsp_buf.sv
// Per-port response slot: valid/err state plus a capture register so read
// data survives back-pressure after the RAM output moves on.
module hicore_tcm_rsp_buf
    import hicore_tcm_ctrl_2p_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  rsp_req_t      req,
    input  logic          rsp_ready,
    input  logic [DW-1:0] ram_dout,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    output logic          free
);

    logic          fresh;   // first response cycle of an in-range read: RAM output is live
    logic [DW-1:0] held;

    assign free = !rsp_valid | rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            fresh     <= 1'b0;
            held      <= '0;
        end else if (req.acc) begin
            rsp_valid <= 1'b1;
            rsp_err   <= req.err;
            fresh     <= req.read & !req.err;
            held      <= '0;
        end else if (rsp_valid & rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            fresh     <= 1'b0;
            held      <= '0;
        end else if (fresh) begin
            held  <= ram_dout;
            fresh <= 1'b0;
        end
    end

    // Writes and errors leave held at zero, so they read back as zero.
    assign rsp_rdata = fresh ? ram_dout : held;

endmodule

// File: rtl/hicore_tcm_ctrl_2p.sv
// Two-port DTCM front end: arbitrates two ICB slave ports onto one single-port RAM.
// Build macro HICORE_TCM_RR_ARB_EN selects round-robin instead of fixed priority.
module hicore_tcm_ctrl_2p
    import hicore_tcm_ctrl_2p_pkg::*;
#(
    parameter int          DW        = HiCore_REG_SIZE,
    parameter int          AW        = HiCore_ADDR_SIZE,
    parameter int          RAM_AW    = TCM_RAM_AW,
    parameter logic [AW-1:0] BASE_ADDR = AW'(TCM_BASE_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    hicore_tcm_ctrl_2p_if.slave p0,
    hicore_tcm_ctrl_2p_if.slave p1,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [DW/8-1:0]   ram_wem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int OFS = byte_ofs_w(DW);
    localparam int HI  = RAM_AW + OFS;

    logic [1:0]                valid, rd, in_rng, free, elig, gnt;
    logic [1:0][AW-1:0]        addr;
    logic [1:0][DW-1:0]        wdata;
    logic [1:0][DW/8-1:0]      wmask;
    rsp_req_t [1:0]            req;
    logic [1:0]                rsp_valid, rsp_err;
    logic [1:0][DW-1:0]        rsp_rdata;
    logic                      sel;
    logic                      unused_lo;

    assign valid = {p1.icb_cmd_valid, p0.icb_cmd_valid};
    assign rd    = {p1.icb_cmd_read,  p0.icb_cmd_read};
    assign addr  = {p1.icb_cmd_addr,  p0.icb_cmd_addr};
    assign wdata = {p1.icb_cmd_wdata, p0.icb_cmd_wdata};
    assign wmask = {p1.icb_cmd_wmask, p0.icb_cmd_wmask};

    // Sub-word address bits carry no meaning for a word-wide RAM.
    assign unused_lo = ^{addr[0][OFS-1:0], addr[1][OFS-1:0]};

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign in_rng[i]   = addr[i][AW-1:HI] == BASE_ADDR[AW-1:HI];
        assign elig[i]     = valid[i] & free[i];
        assign req[i].acc  = gnt[i];
        assign req[i].read = rd[i];
        assign req[i].err  = !in_rng[i];

        hicore_tcm_rsp_buf #(.DW(DW)) u_rsp_buf (
            .clk       (clk),
            .rst       (rst),
            .req       (req[i]),
            .rsp_ready (i == 0 ? p0.icb_rsp_ready : p1.icb_rsp_ready),
            .ram_dout  (ram_dout),
            .rsp_valid (rsp_valid[i]),
            .rsp_err   (rsp_err[i]),
            .rsp_rdata (rsp_rdata[i]),
            .free      (free[i])
        );
    end

`ifdef HICORE_TCM_RR_ARB_EN
    // ptr names the port that wins the next contested cycle.
    port_e ptr;

    always_comb begin
        gnt = elig;
        if (&elig) gnt = (ptr == PORT0) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ptr <= PORT0;
        else if (&elig) ptr <= gnt[0] ? PORT1 : PORT0;
    end
`else
    always_comb begin
        gnt = elig;
        if (elig[0]) gnt[1] = 1'b0;
    end
`endif

    assign sel      = gnt[1];
    assign ram_cs   = |(gnt & in_rng);
    assign ram_we   = ram_cs & ~rd[sel];
    assign ram_wem  = ram_we ? wmask[sel] : '0;
    assign ram_addr = addr[sel][HI-1:OFS];
    assign ram_din  = wdata[sel];

    assign p0.icb_cmd_ready = gnt[0];
    assign p1.icb_cmd_ready = gnt[1];
    assign p0.icb_rsp_valid = rsp_valid[0];
    assign p1.icb_rsp_valid = rsp_valid[1];
    assign p0.icb_rsp_err   = rsp_err[0];
    assign p1.icb_rsp_err   = rsp_err[1];
    assign p0.icb_rsp_rdata = rsp_rdata[0];
    assign p1.icb_rsp_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_hicore_tcm_ctrl_2p.sv
// Self-checking bench for hicore_tcm_ctrl_2p: vector table, corner sequences,
// and a randomized run against a transaction-level model.
module tb_hicore_tcm_ctrl_2p;

    localparam int DW = 32, AW = 32, RAM_AW = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hicore_tcm_ctrl_2p_if #(.AW(AW), .DW(DW)) p0_if ();
    hicore_tcm_ctrl_2p_if #(.AW(AW), .DW(DW)) p1_if ();

    logic              ram_cs, ram_we;
    logic [3:0]        ram_wem;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din, ram_dout;

    hicore_tcm_ctrl_2p dut (
        .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Bench-side port drive / observe arrays
    logic        cv[2], crd[2], rr[2];
    logic [31:0] ca[2], cwd[2];
    logic [3:0]  cm[2];
    logic        cr[2], rv[2], re[2];
    logic [31:0] rdat[2];

    assign p0_if.icb_cmd_valid = cv[0];  assign p1_if.icb_cmd_valid = cv[1];
    assign p0_if.icb_cmd_read  = crd[0]; assign p1_if.icb_cmd_read  = crd[1];
    assign p0_if.icb_cmd_addr  = ca[0];  assign p1_if.icb_cmd_addr  = ca[1];
    assign p0_if.icb_cmd_wdata = cwd[0]; assign p1_if.icb_cmd_wdata = cwd[1];
    assign p0_if.icb_cmd_wmask = cm[0];  assign p1_if.icb_cmd_wmask = cm[1];
    assign p0_if.icb_rsp_ready = rr[0];  assign p1_if.icb_rsp_ready = rr[1];
    assign cr[0] = p0_if.icb_cmd_ready;  assign cr[1] = p1_if.icb_cmd_ready;
    assign rv[0] = p0_if.icb_rsp_valid;  assign rv[1] = p1_if.icb_rsp_valid;
    assign re[0] = p0_if.icb_rsp_err;    assign re[1] = p1_if.icb_rsp_err;
    assign rdat[0] = p0_if.icb_rsp_rdata; assign rdat[1] = p1_if.icb_rsp_rdata;

    // Single-port RAM: output valid only the cycle after a read, garbage otherwise.
    logic [31:0] ram [int];
    logic [31:0] ram_w;
    always @(posedge clk) begin
        ram_dout <= $urandom();
        if (ram_cs) begin
            ram_w = ram.exists(int'(ram_addr)) ? ram[int'(ram_addr)] : 32'h0;
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) ram_w[8*b +: 8] = ram_din[8*b +: 8];
                ram[int'(ram_addr)] = ram_w;
            end else begin
                ram_dout <= ram_w;
            end
        end
    end

    // Reference model: 64 KiB at 0x9000_0000, byte-masked writes.
    bit [31:0] exp_mem [int];

    function automatic bit in_range(input logic [31:0] a);
        return a[31:16] == 16'h9000;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        return exp_mem.exists(int'(a[15:2])) ? exp_mem[int'(a[15:2])] : 32'h0;
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = mread(a);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        exp_mem[int'(a[15:2])] = w;
    endfunction

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wm;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
    } rsp_t;

    vec_t vt[13];
    rsp_t q[2][$];
    rsp_t r;
    int   p;
    bit   acc_prev[2];
    bit   exp_v[2], elig[2], g[2];
    bit   exp_cs;
    bit   rr_ptr;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cv[i] = 0; crd[i] = 0; ca[i] = 0; cwd[i] = 0; cm[i] = 0; rr[i] = 1;
        end

        vt[0]  = '{0, 0, 32'h9000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0};
        vt[1]  = '{0, 1, 32'h9000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF};
        vt[2]  = '{0, 0, 32'h9000_0014, 32'hFFFF_FFFF, 4'hF, 0, 32'h0};
        vt[3]  = '{0, 0, 32'h9000_0014, 32'h1122_3344, 4'h2, 0, 32'h0};
        vt[4]  = '{0, 1, 32'h9000_0014, 32'h0,         4'h0, 0, 32'hFFFF_33FF};
        vt[5]  = '{1, 1, 32'h9000_0013, 32'h0,         4'h0, 0, 32'hDEAD_BEEF};
        vt[6]  = '{0, 1, 32'h8000_0000, 32'h0,         4'h0, 1, 32'h0};
        vt[7]  = '{1, 0, 32'h9000_FFFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0};
        vt[8]  = '{1, 1, 32'h9000_FFFC, 32'h0,         4'h0, 0, 32'hCAFE_F00D};
        vt[9]  = '{0, 1, 32'h9001_0000, 32'h0,         4'h0, 1, 32'h0};
        vt[10] = '{1, 0, 32'h9001_0000, 32'h1234_5678, 4'hF, 1, 32'h0};
        vt[11] = '{0, 1, 32'h9000_0000, 32'h0,         4'h0, 0, 32'h0};
        vt[12] = '{0, 0, 32'h9000_0020, 32'hA5A5_0001, 4'hF, 0, 32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset p%0d rsp_valid", i), rv[i], 0);
            chk($sformatf("reset p%0d rsp_err", i), re[i], 0);
            chk($sformatf("reset p%0d rsp_rdata", i), rdat[i], 0);
        end
        chk("reset ram_cs", ram_cs, 0);
        tick();
        rst = 0;
        tick();

        // Single transactions, one at a time
        for (int i = 0; i < 13; i++) begin
            p = vt[i].port;
            cv[p] = 1; crd[p] = vt[i].rd; ca[p] = vt[i].addr; cwd[p] = vt[i].wdata; cm[p] = vt[i].wm;
            @(negedge clk);
            chk($sformatf("vec%0d cmd_ready", i), cr[p], 1);
            chk($sformatf("vec%0d ram_cs", i), ram_cs, !vt[i].err);
            if (!vt[i].rd && !vt[i].err) mwrite(vt[i].addr, vt[i].wdata, vt[i].wm);
            tick();
            cv[p] = 0;
            @(negedge clk);
            chk($sformatf("vec%0d rsp_valid", i), rv[p], 1);
            chk($sformatf("vec%0d rsp_err", i), re[p], vt[i].err);
            chk($sformatf("vec%0d rsp_rdata", i), rdat[p], vt[i].rdata);
            tick();
        end

        // Both ports read in the same cycle: port 0 first, port 1 next cycle
        cv[0] = 1; crd[0] = 1; ca[0] = 32'h9000_0010;
        cv[1] = 1; crd[1] = 1; ca[1] = 32'h9000_0014;
        @(negedge clk);
        chk("contend p0 cmd_ready", cr[0], 1);
        chk("contend p1 cmd_ready", cr[1], 0);
        tick();
        cv[0] = 0;
        @(negedge clk);
        chk("contend p1 cmd_ready 2nd", cr[1], 1);
        chk("contend p0 rdata", rdat[0], 32'hDEAD_BEEF);
        tick();
        cv[1] = 0;
        @(negedge clk);
        chk("contend p1 rsp_valid", rv[1], 1);
        chk("contend p1 rdata", rdat[1], 32'hFFFF_33FF);
        tick();

        // Back-pressured read while port 1 overwrites the same word
        cv[0] = 1; crd[0] = 1; ca[0] = 32'h9000_0020; rr[0] = 0;
        @(negedge clk);
        chk("hold p0 accept", cr[0], 1);
        tick();
        ca[0] = 32'h9000_0024;
        cv[1] = 1; crd[1] = 0; ca[1] = 32'h9000_0020; cwd[1] = 32'h5A5A_5A5A; cm[1] = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold c%0d rsp_valid", k), rv[0], 1);
            chk($sformatf("hold c%0d rdata", k), rdat[0], 32'hA5A5_0001);
            chk($sformatf("hold c%0d cmd_ready", k), cr[0], 0);
            if (k == 0) chk("hold p1 accept", cr[1], 1);
            tick();
            cv[1] = 0;
        end
        mwrite(32'h9000_0020, 32'h5A5A_5A5A, 4'hF);
        rr[0] = 1;
        @(negedge clk);
        chk("drain rdata", rdat[0], 32'hA5A5_0001);
        chk("drain+accept cmd_ready", cr[0], 1);
        tick();
        ca[0] = 32'h9000_0020;
        @(negedge clk);
        chk("drain next rsp_valid", rv[0], 1);
        chk("drain next rdata", rdat[0], mread(32'h9000_0024));
        tick();
        cv[0] = 0;
        @(negedge clk);
        chk("overwrite readback", rdat[0], 32'h5A5A_5A5A);
        tick();

        // Streaming reads: 16 responses on consecutive cycles
        for (int k = 0; k < 17; k++) begin
            cv[0] = (k < 16); crd[0] = 1; ca[0] = 32'h9000_0000 + 32'(4 * k);
            @(negedge clk);
            if (k < 16) chk($sformatf("stream%0d cmd_ready", k), cr[0], 1);
            if (k > 0) begin
                chk($sformatf("stream%0d rsp_valid", k - 1), rv[0], 1);
                chk($sformatf("stream%0d rdata", k - 1), rdat[0], mread(32'h9000_0000 + 32'(4 * (k - 1))));
            end
            tick();
        end

        // Reset after the 8th accept: the 8th response is lost
        for (int k = 0; k < 8; k++) begin
            cv[0] = 1; crd[0] = 1; ca[0] = 32'h9000_0000 + 32'(4 * k);
            @(negedge clk);
            if (k > 0) chk($sformatf("rststream%0d rdata", k - 1), rdat[0], mread(32'h9000_0000 + 32'(4 * (k - 1))));
            tick();
        end
        cv[0] = 0;
        rst = 1;
        #1;
        chk("mid reset rsp_valid", rv[0], 0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("after reset rsp_valid", rv[0], 0);
        tick();

        // Randomized traffic against the transaction model
        acc_prev[0] = 1; acc_prev[1] = 1; rr_ptr = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!cv[i] || acc_prev[i]) begin
                    cv[i]  = ($urandom_range(3) != 0);
                    crd[i] = 1'($urandom_range(1));
                    ca[i]  = ($urandom_range(7) == 0) ? 32'hA000_0100 : 32'h9000_0100 + 32'(4 * $urandom_range(7));
                    ca[i]  = ca[i] + 32'($urandom_range(3));
                    cwd[i] = $urandom();
                    cm[i]  = 4'($urandom_range(15));
                end
                rr[i] = ($urandom_range(3) != 0);
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                exp_v[i] = q[i].size() > 0;
                chk($sformatf("rnd%0d p%0d rsp_valid", c, i), rv[i], exp_v[i]);
                if (exp_v[i]) begin
                    chk($sformatf("rnd%0d p%0d rsp_err", c, i), re[i], q[i][0].err);
                    chk($sformatf("rnd%0d p%0d rsp_rdata", c, i), rdat[i], q[i][0].rdata);
                end
                elig[i] = cv[i] && (!exp_v[i] || rr[i]);
            end
`ifdef HICORE_TCM_RR_ARB_EN
            if (elig[0] && elig[1]) begin
                g[0] = !rr_ptr; g[1] = rr_ptr; rr_ptr = !rr_ptr;
            end else begin
                g[0] = elig[0]; g[1] = elig[1];
            end
`else
            g[0] = elig[0];
            g[1] = elig[1] && !elig[0];
`endif
            exp_cs = 0;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rnd%0d p%0d cmd_ready", c, i), cr[i], g[i]);
                if (exp_v[i] && rr[i]) void'(q[i].pop_front());
                acc_prev[i] = g[i];
                if (g[i]) begin
                    r.err   = !in_range(ca[i]);
                    r.rdata = (crd[i] && !r.err) ? mread(ca[i]) : 32'h0;
                    q[i].push_back(r);
                    if (!r.err) begin
                        exp_cs = 1;
                        if (!crd[i]) mwrite(ca[i], cwd[i], cm[i]);
                    end
                end
            end
            chk($sformatf("rnd%0d ram_cs", c), ram_cs, exp_cs);
            tick();
        end

        cv[0] = 0; cv[1] = 0; rr[0] = 1; rr[1] = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
